// File: rtl/mux_sel_arbiter_if.sv
// rtl/mux_sel_arbiter_if.sv - operand streams, output stage and debug counters of the select arbiter
interface mux_sel_arbiter_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] a_data;
  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] b_data;
  logic             b_valid;
  logic             b_ready;
  logic             sel;
  logic [WIDTH-1:0] f_data;
  logic             f_valid;
  logic             f_ready;
  logic [CNT_W-1:0] cnt_a;
  logic [CNT_W-1:0] cnt_b;

  // Arbiter side
  modport slave (
    input  a_data, a_valid, b_data, b_valid, f_ready,
    output a_ready, b_ready, sel, f_data, f_valid, cnt_a, cnt_b
  );

  // Sources and consumer side
  modport master (
    output a_data, a_valid, b_data, b_valid, f_ready,
    input  a_ready, b_ready, sel, f_data, f_valid, cnt_a, cnt_b
  );
endinterface

// File: rtl/mux_sel_arbiter.sv
// rtl/mux_sel_arbiter.sv - round-robin 2:1 operand arbiter with registered mux select and output stage
module mux_sel_arbiter #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input logic            clk,
  input logic            rst,
  mux_sel_arbiter_if.slave bus
);
  logic [WIDTH-1:0] f_data_q;
  logic             f_valid_q;
  logic             sel_q;
  logic             last_a_q;
  logic [CNT_W-1:0] cnt_a_q;
  logic [CNT_W-1:0] cnt_b_q;

  logic load;
  logic grant_a;
  logic grant_b;

  // Readies depend only on valids, f_ready and state, never on operand data.
  always_comb begin
    load    = !f_valid_q || bus.f_ready;
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!rst && load) begin
      if (bus.a_valid && bus.b_valid) begin
        grant_a = !last_a_q;
        grant_b = last_a_q;
      end else begin
        grant_a = bus.a_valid;
        grant_b = bus.b_valid;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      f_data_q  <= '0;
      f_valid_q <= 1'b0;
      sel_q     <= 1'b0;
      last_a_q  <= 1'b0;
      cnt_a_q   <= '0;
      cnt_b_q   <= '0;
    end else if (load) begin
      if (grant_a) begin
        f_data_q  <= bus.a_data;
        sel_q     <= 1'b1;
        f_valid_q <= 1'b1;
        last_a_q  <= 1'b1;
        if (cnt_a_q != {CNT_W{1'b1}})
          cnt_a_q <= cnt_a_q + 1'b1;
      end else if (grant_b) begin
        f_data_q  <= bus.b_data;
        sel_q     <= 1'b0;
        f_valid_q <= 1'b1;
        last_a_q  <= 1'b0;
        if (cnt_b_q != {CNT_W{1'b1}})
          cnt_b_q <= cnt_b_q + 1'b1;
      end else begin
        // Nothing to load: stage empties, data/select keep their stale values.
        f_valid_q <= 1'b0;
      end
    end
  end

  assign bus.a_ready = grant_a;
  assign bus.b_ready = grant_b;
  assign bus.f_data  = f_data_q;
  assign bus.f_valid = f_valid_q;
  assign bus.sel     = sel_q;
  assign bus.cnt_a   = cnt_a_q;
  assign bus.cnt_b   = cnt_b_q;
endmodule

// File: doc/mux_sel_arbiter.md
Name: mux_sel_arbiter

Overview:
- Upstream control stage for the 2:1 operand mux.
- Takes two valid/ready operand streams (A, B) and picks one per cycle by round-robin.
- Drives the mux select and registers the chosen operand into a one-deep output stage with valid/ready toward the consumer.
- Keeps per-source saturating beat counters for debug.

Parameters:
- WIDTH, 4, operand width in bits.
- CNT_W, 8, width of each per-source beat counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- a_data  input  WIDTH  operand from source A.
- a_valid  input  1  A operand present.
- a_ready  output  1  A operand accepted this cycle.
- b_data  input  WIDTH  operand from source B.
- b_valid  input  1  B operand present.
- b_ready  output  1  B operand accepted this cycle.
- sel  output  1  registered select: 1 = f_data came from A, 0 = from B (same polarity as the mux: sel ? a : b).
- f_data  output  WIDTH  registered selected operand.
- f_valid  output  1  f_data holds an unconsumed beat.
- f_ready  input  1  consumer accepts f_data this cycle.
- cnt_a  output  CNT_W  beats accepted from A.
- cnt_b  output  CNT_W  beats accepted from B.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: f_valid=0, f_data=0, sel=0, cnt_a=0, cnt_b=0, last_grant=B.
- Reset mid-operation: any beat held in the output register is dropped. a_ready and b_ready are 0 while rst=1.
- Load enable: load = !f_valid || f_ready. The output stage accepts a new beat when empty or when it is draining in the same cycle, giving 1 beat/cycle throughput.
- Arbitration (combinational, evaluated only when load=1):
  - Only a_valid → grant A.
  - Only b_valid → grant B.
  - Both valid → grant the side that is not last_grant. A wins the first tie after reset.
  - Neither valid → no grant.
- Handshakes:
  - a_ready = load && grant==A.
  - b_ready = load && grant==B.
  - At most one ready is high per cycle.
  - Ready may depend combinationally on both valids and on f_ready; there is no combinational path from data to ready.
- On a grant (transfer):
  - f_data ← granted operand.
  - sel ← 1 for A, 0 for B.
  - f_valid ← 1.
  - last_grant ← granted side.
  - Granted counter increments.
  - Latency: 1 cycle from accept to f_valid.
- load=1 with no grant: f_valid ← 0. f_data and sel hold their previous values; they are don't-care for the consumer.
- Backpressure: while f_valid=1 && f_ready=0, f_data, sel and f_valid hold stable and both readies are 0.
- last_grant changes only on an actual transfer. It is not updated on idle cycles or on stalls.
- Counters: saturate at 2^CNT_W−1 and do not wrap. Reset is the only way to clear them.
- Simultaneous drain and refill (f_valid=1, f_ready=1, new grant): new beat replaces old with no bubble.
- Source valid must stay high until accepted. The block does not check this.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, both valids low → f_valid=0, sel=0, f_data=0, cnt_a=cnt_b=0. a_ready=b_ready=0 throughout reset.
- Single source streaming: a_valid=1, a_data=4'h5, f_ready=1 for 3 cycles → f_valid=1 from cycle 1 with f_data=4'h5, sel=1, cnt_a=3, cnt_b=0, b_ready never high.
- Round-robin tie: both valid continuously (a_data=4'h3, b_data=4'hC), f_ready=1 → grants alternate A,B,A,B. f_data sequence 3,C,3,C with sel 1,0,1,0; cnt_a=cnt_b=2 after 4 beats.
- Backpressure: beat from B (b_data=4'h9) registered, f_ready=0 for 4 cycles with a_valid=1 → f_data=4'h9, sel=0 held, a_ready=0 throughout. f_ready=1 then accepts A next cycle, f_data=A operand, sel=1.
- Counter saturation: CNT_W=2, stream 6 beats from A → cnt_a sequence 1,2,3,3,3,3.
- Reset mid-stream: rst=1 while f_valid=1 with f_ready=0 → next cycle f_valid=0, counters 0, last_grant=B. A is granted first on the next tie.
